hci_l2_bank_arbiter: RTL and testbench
======================================

// Module: hci_l2_bank_arbiter
// PURPOSE
//  Shares one L2 memory bank port among N_CH0+N_CH1 HCI-style requesters.
//  Two-class priority: CH1 (DMA/ext) outranks CH0 (cores) by default, selectable at runtime.
//  Round-robin inside each class; a starvation counter forces a low-class win after MAX_STALL cycles.
//  Routes the 1-cycle-latency bank response back to the initiator that was granted.
// PARAMETERS
//  N_CH0      4   number of class-0 (core) requesters, indices 0..N_CH0-1
//  N_CH1      2   number of class-1 requesters, indices N_CH0..N_CH0+N_CH1-1 (>=1 each class)
//  AW         32  byte address width
//  DW         32  data width
//  BW         8   bits per byte-enable lane
//  MAX_STALL  8   max consecutive denied low-class cycles; 0 = strict priority, no anti-starvation
//  N          N_CH0+N_CH1 (localparam); IW = max(1,$clog2(N)) (localparam)
// PORTS
//  clk_i         in   1          clock, all state on rising edge
//  rst_i         in   1          synchronous active-high reset
//  prio_ch0_i    in   1          0: CH1 is high class; 1: CH0 is high class
//  req_i         in   N          per-requester request
//  add_i         in   N*AW       per-requester address
//  wen_i         in   N          1 = read, 0 = write
//  wdata_i       in   N*DW       write data
//  be_i          in   N*DW/BW    byte enables
//  gnt_o         out  N          one-hot grant, combinational
//  r_valid_o     out  N          one-hot response valid
//  r_data_o      out  DW         response data, shared by all requesters
//  mem_req_o     out  1          bank request
//  mem_add_o     out  AW         selected address
//  mem_wen_o     out  1          selected wen
//  mem_wdata_o   out  DW         selected wdata
//  mem_be_o      out  DW/BW      selected be
//  mem_gnt_i     in   1          bank grant
//  mem_r_data_i  in   DW         bank read data, valid 1 cycle after accepted request
//  starve_o      out  1          starvation override active this cycle (debug/perf)
// BEHAVIOUR
//  Reset (rst_i=1 at edge): rr_ch0=0, rr_ch1=0, stall_cnt=0, r_pend_q=0, r_id_q=0.
//   Then r_valid_o=0, starve_o=0; gnt_o/mem_req_o=0 while req_i=0.
//  Accept = mem_req_o & mem_gnt_i. mem_req_o = |req_i.
//  Class RR: pick first asserted req at or after class pointer, wrapping within class.
//   On accept, winner's class pointer <= (winner_local_idx+1) mod class size; other pointer holds.
//  Selection (comb): starve_o = (MAX_STALL>0) & (stall_cnt==MAX_STALL) & low has req.
//   starve_o ? low RR winner : (high has req ? high RR winner : low RR winner).
//  mem_add/wen/wdata/be_o = selected requester's fields; 0 when no req.
//  gnt_o[sel] = accept; all other gnt_o bits 0. No grant to a non-requesting index.
//  stall_cnt (width $clog2(MAX_STALL+1)), updated at edge:
//   cleared if low has no req, low winner accepted, or prio_ch0_i toggles vs last cycle;
//   else +1 saturating at MAX_STALL (also counts cycles where mem_gnt_i=0).
//  Response: on accept r_pend_q<=1, r_id_q<=sel; else r_pend_q<=0.
//   r_valid_o = r_pend_q ? onehot(r_id_q) : 0. Reads and writes both get r_valid.
//   r_data_o = mem_r_data_i (passthrough).
//  Back-to-back accepts allowed every cycle; throughput 1 txn/cycle.
//  mem_gnt_i=0: no pointer move, no r_valid next cycle; selection may change with req_i.
//  prio_ch0_i change: takes effect same cycle; stall_cnt cleared next edge.
//  Reset mid-operation: in-flight response dropped; r_valid_o=0 the cycle after reset.
// TESTING
//  T1 reset then idle: rst_i=1 2 cycles, req_i=0 -> gnt_o=0, r_valid_o=0, mem_req_o=0.
//  T2 RR in CH0: req_i=4'b1111 (CH1 idle), mem_gnt_i=1 -> grants 0,1,2,3,0; r_valid one cycle later each.
//  T3 priority: req_i[0]=1, req_i[4]=1, prio_ch0_i=0 -> gnt_o[4]; set prio_ch0_i=1 -> gnt_o[0] same cycle.
//  T4 starvation: MAX_STALL=8, req[4],req[0] held, prio_ch0_i=0 -> 8 grants to 4, 9th to 0 with starve_o=1, counter cleared.
//  T5 backpressure: mem_gnt_i=0 for 3 cycles with req_i=6'b000011 -> gnt_o=0, rr_ch0 held; on gnt grant to 0, then 1.
//  T6 read data: accept read from idx 5, mem_r_data_i=32'hDEADBEEF next cycle -> r_valid_o=6'b100000, r_data_o=32'hDEADBEEF.

Source files
------------

// File: rtl/hci_l2_bank_arbiter.sv
// hci_l2_bank_arbiter
// Shares one L2 bank port among N_CH0 class-0 (core) and N_CH1 class-1
// (DMA/external) requesters. One class is high priority, picked at run time
// by prio_ch0_i. Each class is served round-robin. A stall counter forces a
// low-class win once the low class has been denied MAX_STALL cycles in a row.
// The 1-cycle-latency bank response is routed back to the granted initiator.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   prio_ch0_i           0: class 1 is high priority, 1: class 0 is high priority
//   req_i/add_i/wen_i/   per-requester request, address, read(1)/write(0),
//   wdata_i/be_i         write data and byte enables (flattened, index 0 in LSBs)
//   gnt_o                one-hot grant (combinational, only on bank accept)
//   r_valid_o, r_data_o  one-hot response valid, shared response data
//   mem_*                bank-side request channel and read data
//   starve_o             anti-starvation override selected the winner this cycle
module hci_l2_bank_arbiter #(
  parameter int N_CH0     = 4,
  parameter int N_CH1     = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BW        = 8,
  parameter int MAX_STALL = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                prio_ch0_i,
  input  logic [N_CH0+N_CH1-1:0]              req_i,
  input  logic [(N_CH0+N_CH1)*AW-1:0]         add_i,
  input  logic [N_CH0+N_CH1-1:0]              wen_i,
  input  logic [(N_CH0+N_CH1)*DW-1:0]         wdata_i,
  input  logic [(N_CH0+N_CH1)*(DW/BW)-1:0]    be_i,
  output logic [N_CH0+N_CH1-1:0]              gnt_o,
  output logic [N_CH0+N_CH1-1:0]              r_valid_o,
  output logic [DW-1:0]                       r_data_o,
  output logic                                mem_req_o,
  output logic [AW-1:0]                       mem_add_o,
  output logic                                mem_wen_o,
  output logic [DW-1:0]                       mem_wdata_o,
  output logic [DW/BW-1:0]                    mem_be_o,
  input  logic                                mem_gnt_i,
  input  logic [DW-1:0]                       mem_r_data_i,
  output logic                                starve_o
);

  localparam int N   = N_CH0 + N_CH1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BEW = DW / BW;
  localparam int PW0 = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
  localparam int PW1 = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
  localparam int SW  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  // Round-robin pick inside one class: returns {found, global index}.
  // Scans from the farthest slot back to the pointer so the last hit kept
  // is the first requester at or after the pointer.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input int base,
                                          input int size, input int ptr);
    logic [IW:0]  res;
    logic [N-1:0] shifted;
    int           j;
    res = '0;
    for (int k = size - 1; k >= 0; k--) begin
      j       = (ptr + k >= size) ? (ptr + k - size) : (ptr + k);
      shifted = req >> (base + j);
      res     = shifted[0] ? {1'b1, IW'(base + j)} : res;
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  logic [PW0-1:0] rr_ch0_r;
  logic [PW1-1:0] rr_ch1_r;
  logic [SW-1:0]  stall_cnt_r;
  logic           r_pend_r;
  logic [IW-1:0]  r_id_r;
  logic           prio_last_r;

  logic [IW:0]    ch0_pick_s, ch1_pick_s, high_pick_s, low_pick_s;
  logic [IW-1:0]  sel_s;
  logic           sel_valid_s, sel_low_s, starve_s, accept_s;
  logic [PW0-1:0] ptr0_next_s;
  logic [PW1-1:0] ptr1_next_s;
  logic [SW-1:0]  stall_next_s;

  // Winner selection: class RR picks, then class priority with starvation override.
  always_comb begin
    ch0_pick_s = rr_pick(req_i, 0, N_CH0, int'(rr_ch0_r));
    ch1_pick_s = rr_pick(req_i, N_CH0, N_CH1, int'(rr_ch1_r));
    if (prio_ch0_i) begin
      high_pick_s = ch0_pick_s;
      low_pick_s  = ch1_pick_s;
    end else begin
      high_pick_s = ch1_pick_s;
      low_pick_s  = ch0_pick_s;
    end
    starve_s = (MAX_STALL > 0) && (stall_cnt_r == STALL_MAX) && low_pick_s[IW];
    if (starve_s || !high_pick_s[IW]) begin
      sel_s     = low_pick_s[IW-1:0];
      sel_low_s = 1'b1;
    end else begin
      sel_s     = high_pick_s[IW-1:0];
      sel_low_s = 1'b0;
    end
    sel_valid_s = |req_i;
    accept_s    = sel_valid_s & mem_gnt_i;
  end

  // Bank request mux, grant and response routing.
  always_comb begin
    mem_req_o = sel_valid_s;
    if (sel_valid_s) begin
      mem_add_o   = AW'(add_i >> (int'(sel_s) * AW));
      mem_wen_o   = wen_i[sel_s];
      mem_wdata_o = DW'(wdata_i >> (int'(sel_s) * DW));
      mem_be_o    = BEW'(be_i >> (int'(sel_s) * BEW));
    end else begin
      mem_add_o   = '0;
      mem_wen_o   = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
    end
    gnt_o     = accept_s ? onehot(sel_s) : '0;
    starve_o  = starve_s;
    r_valid_o = r_pend_r ? onehot(r_id_r) : '0;
    r_data_o  = mem_r_data_i;
  end

  // Next pointer for the winner's class and next stall count.
  always_comb begin
    ptr0_next_s = rr_ch0_r;
    ptr1_next_s = rr_ch1_r;
    if (int'(sel_s) < N_CH0) begin
      if (int'(sel_s) == N_CH0 - 1) ptr0_next_s = '0;
      else                          ptr0_next_s = PW0'(int'(sel_s) + 1);
    end else begin
      if (int'(sel_s) == N - 1) ptr1_next_s = '0;
      else                      ptr1_next_s = PW1'(int'(sel_s) - N_CH0 + 1);
    end
    // A priority flip restarts the starvation window for the new low class.
    if (!low_pick_s[IW] || (accept_s && sel_low_s) || (prio_ch0_i != prio_last_r)) begin
      stall_next_s = '0;
    end else if (stall_cnt_r == STALL_MAX) begin
      stall_next_s = stall_cnt_r;
    end else begin
      stall_next_s = stall_cnt_r + SW'(1);
    end
  end

  // Arbiter state: RR pointers, stall counter, pending response tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ch0_r    <= '0;
      rr_ch1_r    <= '0;
      stall_cnt_r <= '0;
      r_pend_r    <= 1'b0;
      r_id_r      <= '0;
      prio_last_r <= prio_ch0_i;
    end else begin
      if (accept_s) begin
        rr_ch0_r <= ptr0_next_s;
        rr_ch1_r <= ptr1_next_s;
        r_id_r   <= sel_s;
      end
      r_pend_r    <= accept_s;
      stall_cnt_r <= stall_next_s;
      prio_last_r <= prio_ch0_i;
    end
  end

endmodule

// File: tb/tb_hci_l2_bank_arbiter.sv
module tb_hci_l2_bank_arbiter;

  localparam int N_CH0 = 4;
  localparam int N_CH1 = 2;
  localparam int N     = 6;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int BEW   = 4;
  localparam int MAX_STALL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              prio = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   add_v = '0;
  logic [N-1:0]      wen = '0;
  logic [N*DW-1:0]   wdata_v = '0;
  logic [N*BEW-1:0]  be_v = '0;
  logic [N-1:0]      gnt, r_valid;
  logic [DW-1:0]     r_data;
  logic              mem_req, mem_wen, starve;
  logic [AW-1:0]     mem_add;
  logic [DW-1:0]     mem_wdata;
  logic [BEW-1:0]    mem_be;
  logic              mem_gnt = 1'b1;
  logic [DW-1:0]     mem_r_data = '0;

  logic [AW-1:0]  add_a [N];
  logic [DW-1:0]  wd_a  [N];
  logic [BEW-1:0] be_a  [N];

  int checks = 0;
  int errors = 0;

  hci_l2_bank_arbiter #(
    .N_CH0(N_CH0), .N_CH1(N_CH1), .AW(AW), .DW(DW), .BW(BW), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .prio_ch0_i(prio), .req_i(req), .add_i(add_v),
    .wen_i(wen), .wdata_i(wdata_v), .be_i(be_v), .gnt_o(gnt), .r_valid_o(r_valid),
    .r_data_o(r_data), .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_r_data_i(mem_r_data), .starve_o(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after ptr inside a class, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] r, input int base, input int size, input int ptr);
    for (int k = 0; k < size; k++) begin
      int j;
      j = (ptr + k) % size;
      if (r[base + j]) return base + j;
    end
    return -1;
  endfunction

  // Behavioural model state
  int   m_ptr0, m_ptr1, m_stall, m_id;
  bit   m_pend, m_prio_last, model_on = 1'b0;
  int   e_sel, e_lw;
  bit   e_acc;

  // Compare process: derive expected outputs from the rules and compare every cycle.
  always @(negedge clk) begin : cmp
    int c0, c1, hw, lw, sel;
    bit st, acc;
    logic [N-1:0] one6, exp_gnt, exp_rv;
    if (model_on) begin
      one6 = 6'b000001;
      c0 = pick(req, 0, N_CH0, m_ptr0);
      c1 = pick(req, N_CH0, N_CH1, m_ptr1);
      hw = prio ? c0 : c1;
      lw = prio ? c1 : c0;
      st = (MAX_STALL > 0) && (m_stall == MAX_STALL) && (lw >= 0);
      sel = st ? lw : ((hw >= 0) ? hw : lw);
      acc = (sel >= 0) && mem_gnt;
      exp_gnt = acc ? (one6 << sel) : 6'b000000;
      exp_rv  = m_pend ? (one6 << m_id) : 6'b000000;
      chk("gnt", gnt, exp_gnt);
      chk("r_valid", r_valid, exp_rv);
      chk("r_data", r_data, mem_r_data);
      chk("starve", starve, st);
      chk("mem_req", mem_req, (req != 6'b000000));
      chk("mem_add", mem_add, (sel >= 0) ? add_a[sel] : 32'h0);
      chk("mem_wen", mem_wen, (sel >= 0) ? wen[sel] : 1'b0);
      chk("mem_wdata", mem_wdata, (sel >= 0) ? wd_a[sel] : 32'h0);
      chk("mem_be", mem_be, (sel >= 0) ? be_a[sel] : 4'h0);
      e_sel = sel;
      e_lw  = lw;
      e_acc = acc;
    end
  end

  // Model state update at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_ptr0      <= 0;
      m_ptr1      <= 0;
      m_stall     <= 0;
      m_pend      <= 1'b0;
      m_id        <= 0;
      m_prio_last <= prio;
      model_on    <= 1'b1;
    end else if (model_on) begin
      m_pend <= e_acc;
      if (e_acc) begin
        m_id <= e_sel;
        if (e_sel < N_CH0) m_ptr0 <= (e_sel + 1) % N_CH0;
        else               m_ptr1 <= (e_sel - N_CH0 + 1) % N_CH1;
      end
      if (e_lw < 0 || (e_acc && e_sel == e_lw) || prio != m_prio_last) m_stall <= 0;
      else if (m_stall < MAX_STALL) m_stall <= m_stall + 1;
      m_prio_last <= prio;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] req_tab [8] = '{6'b110011, 6'b100001, 6'b011110, 6'b110000,
                              6'b001010, 6'b111111, 6'b010100, 6'b100110};

  initial begin : main
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] one6;
    int count4;
    bit found;
    one6 = 6'b000001;
    for (int i = 0; i < N; i++) begin
      add_a[i] = 32'h1000_0000 + 32'(i * 16);
      wd_a[i]  = 32'hA000_0000 + 32'(i);
      be_a[i]  = 4'hF ^ 4'(i);
      add_v[i*AW +: AW]    = add_a[i];
      wdata_v[i*DW +: DW]  = wd_a[i];
      be_v[i*BEW +: BEW]   = be_a[i];
    end

    // T1: reset then idle
    step(); step();
    @(negedge clk);
    chk("t1_gnt", gnt, 6'b000000);
    chk("t1_rvalid", r_valid, 6'b000000);
    chk("t1_memreq", mem_req, 1'b0);
    chk("t1_starve", starve, 1'b0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t1_idle_memreq", mem_req, 1'b0);

    // T2: round robin among the four cores
    step(); req = 6'b001111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_gnt", gnt, one6 << exp_seq[i]);
      if (i > 0) chk("t2_rvalid", r_valid, one6 << exp_seq[i-1]);
      step();
    end
    req = 6'b000000;
    @(negedge clk);
    chk("t2_rvalid_last", r_valid, 6'b000001);

    // T3: class priority, switch takes effect the same cycle
    step(); req = 6'b010001; prio = 1'b0;
    @(negedge clk);
    chk("t3_ch1_high", gnt, 6'b010000);
    step(); prio = 1'b1;
    @(negedge clk);
    chk("t3_ch0_high", gnt, 6'b000001);
    step(); req = 6'b000000; prio = 1'b0;
    @(negedge clk);

    // T4: starvation override after MAX_STALL denied cycles
    step(); req = 6'b010001;
    count4 = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (gnt == 6'b000001) begin
        found = 1'b1;
        chk("t4_starve_on", starve, 1'b1);
      end else begin
        if (gnt == 6'b010000) count4++;
        step();
      end
    end
    chk("t4_found", found, 1'b1);
    chk("t4_count", count4, 8);
    step();
    @(negedge clk);
    chk("t4_after_gnt", gnt, 6'b010000);
    chk("t4_after_starve", starve, 1'b0);

    // Reset while a request is being accepted drops the response
    step(); req = 6'b100000; rst = 1'b1;
    @(negedge clk);
    step(); req = 6'b000000; rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_rvalid", r_valid, 6'b000000);

    // T5: backpressure holds the pointer
    step(); req = 6'b000011; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_gnt", gnt, 6'b000000);
      chk("t5_add", mem_add, 32'h1000_0000);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("t5_gnt0", gnt, 6'b000001);
    chk("t5_no_rvalid", r_valid, 6'b000000);
    step();
    @(negedge clk);
    chk("t5_gnt1", gnt, 6'b000010);
    chk("t5_rvalid0", r_valid, 6'b000001);
    step(); req = 6'b000000;

    // T6: read from requester 5 and its response
    step(); req = 6'b100000; wen = 6'b100000;
    @(negedge clk);
    chk("t6_gnt", gnt, 6'b100000);
    chk("t6_wen", mem_wen, 1'b1);
    chk("t6_add", mem_add, 32'h1000_0050);
    step(); req = 6'b000000; mem_r_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t6_rvalid", r_valid, 6'b100000);
    chk("t6_rdata", r_data, 32'hDEADBEEF);

    // Mixed directed sweep checked by the model
    for (int i = 0; i < 144; i++) begin
      step();
      req        = req_tab[(i / 12) % 8];
      prio       = ((i / 40) % 2) == 1;
      mem_gnt    = (i % 7) != 3;
      wen        = 6'(i * 5);
      mem_r_data = 32'h1234_0000 + 32'(i);
    end
    step(); req = 6'b000000;
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
